// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and occupancy decode for the skid stage
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Number of held entries for a given state.
  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      ST_BUSY: occ_of = OCC_BUSY;
      ST_FULL: occ_of = OCC_FULL;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating event counter with synchronous clear
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  // Count up on inc, stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry registered pipeline stage with skid buffer
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NFIELD = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NFIELD*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NFIELD*DATA_W-1:0] out_data,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int W = NFIELD * DATA_W;

  state_t         state;
  state_t         state_n;
  logic [W-1:0]   main_q;
  logic [W-1:0]   main_n;
  logic [W-1:0]   skid_q;
  logic [W-1:0]   skid_n;
  logic           out_valid_q;
  logic [1:0]     occ_q;
  logic           in_fire;
  logic           out_fire;
  logic           stall_inc;

  // Ready depends only on registered state and reset, so upstream never sees
  // a combinational path from out_ready.
  assign in_ready  = (state != ST_FULL) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign stall_inc = out_valid_q && !out_ready && !flush;

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  // Next-state and datapath steering; flush overrides any transfer.
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          main_n  = in_data;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_n = in_data;
        end else if (in_fire) begin
          skid_n  = in_data;
          state_n = ST_FULL;
        end else if (out_fire) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_n  = skid_q;
          state_n = ST_BUSY;
        end
      end
      default: begin
        state_n = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_n = ST_EMPTY;
      main_n  = '0;
      skid_n  = '0;
    end
  end

  // State, storage and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      occ_q       <= OCC_EMPTY;
    end else begin
      state       <= state_n;
      main_q      <= main_n;
      skid_q      <= skid_n;
      out_valid_q <= (state_n != ST_EMPTY);
      occ_q       <= occ_of(state_n);
    end
  end

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .clr  (1'b0),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage
module tb_pipe_skid_stage;

  localparam int DATA_W   = 8;
  localparam int NFIELD   = 3;
  localparam int CNT_W    = 4;
  localparam int W        = NFIELD * DATA_W;
  localparam int STALL_MX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;
  bit sb_on   = 1'b0;

  logic [W-1:0] exp_q[$];
  int           model_occ = 0;
  int           stall_m   = 0;
  bit           ov_m, ir_m;
  bit           hold_prev = 1'b0;
  logic [W-1:0] data_prev = '0;
  logic [W-1:0] exp_word;

  pipe_skid_stage #(
    .DATA_W(DATA_W),
    .NFIELD(NFIELD),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pk(input logic [7:0] v);
    return {v ^ 8'h5A, v ^ 8'hA5, v};
  endfunction

  // Reference model: occupancy is the number of accepted-but-not-delivered
  // entries; acceptance/delivery follow the handshake rules directly.
  always @(negedge clk) begin
    if (sb_on) begin
      ov_m = (model_occ != 0);
      ir_m = !rst && (model_occ != 2);
      chk("sb_occupancy", 32'(occupancy), 32'(model_occ));
      chk("sb_out_valid", 32'(out_valid), 32'(ov_m));
      chk("sb_in_ready", 32'(in_ready), 32'(ir_m));
      chk("sb_stall_cnt", 32'(stall_cnt), 32'(stall_m));
      if (rst) begin
        exp_q.delete();
        model_occ = 0;
        stall_m   = 0;
      end else begin
        if (ov_m && !out_ready && !flush && stall_m < STALL_MX) stall_m++;
        if (flush) begin
          exp_q.delete();
          model_occ = 0;
        end else begin
          if (ov_m && out_ready) model_occ--;
          if (in_valid && ir_m) begin
            exp_q.push_back(in_data);
            model_occ++;
          end
        end
      end
    end
  end

  // Output monitor: every delivered word must be the oldest expected one,
  // and a stalled word must not change.
  always @(negedge clk) begin
    if (sb_on) begin
      if (hold_prev) chk("out_data_stable", 32'(out_data), 32'(data_prev));
      if (!rst && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_output: got 0x%0h expected none at %0t", out_data, $time);
        end else begin
          exp_word = exp_q.pop_front();
          chk("sb_out_data", 32'(out_data), 32'(exp_word));
        end
      end
      hold_prev = !rst && !flush && out_valid && !out_ready;
      data_prev = out_data;
    end
  end

  initial begin
    // reset
    cyc();
    cyc();
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    sb_on = 1'b1;
    rst = 1'b0;
    cyc();
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_occupancy", 32'(occupancy), 32'd0);
    chk("rel_out_data", 32'(out_data), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_stall_cnt", 32'(stall_cnt), 32'd0);

    // streaming at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = pk(8'(i * 8'h11));
      cyc();
      chk("stream_out_data", 32'(out_data), 32'(pk(8'(i * 8'h11))));
      chk("stream_occupancy", 32'(occupancy), 32'd1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_drained", 32'(occupancy), 32'd0);

    // backpressure into the skid register
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pk(8'h0A);
    cyc();
    in_data = pk(8'h0B);
    cyc();
    in_valid = 1'b0;
    chk("bp_occupancy", 32'(occupancy), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_data", 32'(out_data), 32'(pk(8'h0A)));
    out_ready = 1'b1;
    cyc();
    chk("bp_second_data", 32'(out_data), 32'(pk(8'h0B)));
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    cyc();
    chk("bp_drained", 32'(occupancy), 32'd0);

    // flush while full with a simultaneous offer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pk(8'h0D);
    cyc();
    in_data = pk(8'h0E);
    cyc();
    flush   = 1'b1;
    in_data = pk(8'h0C);
    cyc();
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("flush_no_c", 32'(out_valid), 32'd0);

    // stall counter saturation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pk(8'h05);
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    chk("stall_saturated", 32'(stall_cnt), 32'(STALL_MX));
    out_ready = 1'b1;
    cyc();

    // reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pk(8'h01);
    cyc();
    in_data = pk(8'h02);
    cyc();
    in_valid = 1'b0;
    chk("rfull_occupancy_pre", 32'(occupancy), 32'd2);
    rst = 1'b1;
    #1;
    chk("rfull_in_ready_during", 32'(in_ready), 32'd0);
    cyc();
    chk("rfull_occupancy", 32'(occupancy), 32'd0);
    chk("rfull_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rfull_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rfull_in_ready_after", 32'(in_ready), 32'd1);

    // randomized valid/ready traffic with occasional flush
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = W'($urandom);
      cyc();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one payload field.
REQ-002 SHALL have parameter NFIELD, default 2, number of payload fields carried per transfer.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-009 SHALL have port in_data  input  NFIELD*DATA_W  payload; field k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port out_data  output  NFIELD*DATA_W  payload of the oldest held entry.
REQ-013 SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Input transfer SHALL occur on a rising edge where in_valid=1, in_ready=1, rst=0 and flush=0.
REQ-016 Output transfer SHALL occur on a rising edge where out_valid=1, out_ready=1, rst=0 and flush=0.
REQ-017 Storage SHALL be a main register driving out_data plus one skid register; FSM states are EMPTY (0 entries), BUSY (1 entry) and FULL (2 entries).
REQ-018 EMPTY + input transfer SHALL load main and go to BUSY; out_valid=1 on the next cycle, giving a latency of 1 cycle.
REQ-019 BUSY with input and output transfer together SHALL load main with in_data and stay in BUSY, so full throughput is 1 transfer per cycle.
REQ-020 BUSY with input transfer and no output transfer SHALL load skid and go to FULL.
REQ-021 BUSY with output transfer and no input transfer SHALL go to EMPTY.
REQ-022 FULL with output transfer SHALL move skid to main and go to BUSY.
REQ-023 in_ready SHALL equal (state != FULL) and rst=0, with no combinational path from out_ready or in_valid.
REQ-024 out_valid SHALL equal (state != EMPTY); occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-025 Entries SHALL leave in acceptance order, and no entry SHALL be dropped or duplicated except by flush or rst.
REQ-026 flush=1 SHALL set state to EMPTY and clear main and skid to 0 on that edge, takes priority over any simultaneous input or output transfer (both discarded), and SHALL leave stall_cnt unchanged.
REQ-027 While out_valid=1, out_data SHALL remain stable until an output transfer, flush or rst.
REQ-028 stall_cnt SHALL increment by 1 on each edge with out_valid=1, out_ready=0 and flush=0, and SHALL hold at 2^CNT_W-1 without wrapping.

Reset
REQ-029 rst=1 SHALL force state EMPTY, main and skid to 0 and stall_cnt to 0 on the next edge, overriding flush and any transfer, including mid-operation in FULL.
REQ-030 During rst=1, in_ready SHALL read 0; after reset release, out_valid=0, occupancy=0, out_data=0 and in_ready=1.

Structure
REQ-031 The state enum (EMPTY/BUSY/FULL) and the occupancy encoding SHALL live in shared package pipe_pkg.
REQ-032 The saturating stall counter SHALL be the sub-module pipe_sat_cnt (parameter CNT_W; ports clk, rst, inc, clr, count).
REQ-033 All outputs SHALL be driven directly from registers, except in_ready, which is decoded from the state register and rst.

Verification
REQ-034 Bench SHALL cover streaming: out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles -> each appears exactly 1 cycle later, occupancy stays 1, and in_ready stays 1.
REQ-035 Bench SHALL cover backpressure: out_ready=0, inputs 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA; then out_ready=1 -> outputs 0xA then 0xB, and in_ready=1 one cycle after the first output transfer.
REQ-036 Bench SHALL cover flush in FULL with simultaneous in_valid=1 of 0xC -> next cycle occupancy 0, out_valid=0, out_data=0, and 0xC is never output.
REQ-037 Bench SHALL cover stall saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds.
REQ-038 Bench SHALL cover reset in FULL: rst=1 for one cycle -> occupancy 0, stall_cnt 0, in_ready 0 during rst and 1 after.
REQ-039 Bench SHALL cover random valid/ready with NFIELD=3, DATA_W=8 against a reference queue -> output sequence matches the queue, no loss or duplication, and occupancy never exceeds 2.
